arbitro_memoria_datos: RTL and testbench
========================================

# arbitro_memoria_datos

Controller that shares the BIP I data memory (`memoria_datos`, 16-bit × 1024, low-latency registered read) between the CPU datapath and a built-in dump sequencer. The dump sequencer streams the full memory contents to the debug/UART unit over a valid/ready interface. The CPU always has absolute priority and never stalls. The dump sequencer uses only the cycles in which the CPU does not access memory. The block sits between the CPU, `memoria_datos` and the debug unit.

## Interface
- `RAM_WIDTH`, 16: data word width.
- `ADDR_WIDTH`, 11: memory address width.
- `DUMP_LEN`, 1024: number of words dumped, addresses 0..DUMP_LEN-1; must satisfy DUMP_LEN ≤ 2^ADDR_WIDTH.
- `i_clk` in 1: system clock; all state updates on the rising edge.
- `i_reset` in 1: reset, asynchronous, active-low.
- `i_cpu_en` in 1: CPU accesses memory this cycle.
- `i_cpu_wea` in 1: CPU write enable; qualified by `i_cpu_en`.
- `i_cpu_addr` in ADDR_WIDTH: CPU address.
- `i_cpu_data` in RAM_WIDTH: CPU write data.
- `o_cpu_data` out RAM_WIDTH: CPU read data; equals `i_mem_data`.
- `o_mem_addr` out ADDR_WIDTH: address to `memoria_datos`.
- `o_mem_data` out RAM_WIDTH: write data to `memoria_datos`; equals `i_cpu_data`.
- `o_mem_wea` out 1: write enable to `memoria_datos`.
- `i_mem_data` in RAM_WIDTH: memory read data; valid 1 cycle after its address.
- `i_dump_start` in 1: request a full dump; single-cycle pulse or level.
- `i_dump_ready` in 1: debug unit accepts a word.
- `o_dump_valid` out 1: dump word available.
- `o_dump_data` out RAM_WIDTH: dump word.
- `o_dump_addr` out ADDR_WIDTH: address of the current dump word.
- `o_dump_busy` out 1: sequencer not IDLE.
- `o_dump_done` out 1: 1-cycle pulse after the last word is accepted.

## Operation
- Memory port mux (combinational):
  - When `i_cpu_en`=1: `o_mem_addr`=`i_cpu_addr`, `o_mem_wea`=`i_cpu_wea`.
  - Otherwise, in state ISSUE: `o_mem_addr`=dump counter, `o_mem_wea`=0.
  - Otherwise: `o_mem_addr`=`i_cpu_addr`, `o_mem_wea`=0.
  - The dump sequencer never writes memory.
- Dump FSM states and transitions:
  - IDLE: on `i_dump_start`=1, clear the counter and go to ISSUE.
  - ISSUE: if `i_cpu_en`=0, the read is issued this cycle; go to WAIT. If `i_cpu_en`=1, stay in ISSUE (retry).
  - WAIT: register `i_mem_data` into `o_dump_data` and the counter into `o_dump_addr`; go to HOLD.
  - HOLD: `o_dump_valid`=1. On `i_dump_ready`=1:
    - If counter = DUMP_LEN-1, go to IDLE and pulse `o_dump_done`.
    - Otherwise, increment the counter and go to ISSUE.
- `o_dump_data` and `o_dump_addr` stay stable in HOLD until the word is accepted.
- `i_dump_start` while busy is ignored. No restart happens on the same cycle as `o_dump_done`.
- Coherency: each word is a snapshot taken at the moment it is read. CPU writes to addresses not yet dumped are reflected; writes to addresses already dumped are not. No locking.
- The counter is ADDR_WIDTH wide. It never wraps within a dump; termination is by comparison with DUMP_LEN-1.

## Timing
- Reset values:
  - FSM = IDLE, counter = 0.
  - `o_dump_valid`, `o_dump_busy`, `o_dump_done` = 0.
  - `o_dump_data` = 0, `o_dump_addr` = 0.
  - Memory-side outputs follow the mux rule, so `o_mem_wea` = `i_cpu_en & i_cpu_wea`.
- CPU path: zero added latency. The mux is combinational. Read data arrives 1 cycle after the address (memory latency).
- Dump path:
  - First `o_dump_valid` occurs 3 cycles after `i_dump_start`, with no CPU contention and ready held high.
  - Throughput is one word per 3 cycles, plus one cycle per cycle in which ISSUE is blocked by `i_cpu_en`.
- `o_dump_busy` = 1 from the cycle after start until the cycle of the `o_dump_done` pulse, inclusive.
- Asynchronous reset mid-dump aborts immediately: all outputs return to reset values and no done pulse is produced.
- The CPU is never blocked, including when `i_cpu_en`=1 continuously. In that case the dump stalls in ISSUE indefinitely.

## Structure
- Header include file `arbitro_memoria_datos.vh` holds:
  - FSM state encodings (IDLE, ISSUE, WAIT, HOLD; 2 bits).
  - Default width constants shared with `memoria_datos`.
- One sub-module, `secuenciador_dump`, contains the FSM, counter, holding register and handshake.
- The top module contains the memory port mux and instantiates `secuenciador_dump`.

## Test plan
- Memory preloaded with mem[a]=a+16'h0100, DUMP_LEN=4, `i_cpu_en`=0, ready high; pulse start → words 0x0100..0x0103 with addresses 0..3, one per 3 cycles, then a single `o_dump_done` pulse.
- CPU writes 16'h000F to address 0, then 16'h0002 to address 1, then reads addresses 0 and 1 → `o_cpu_data`=0x000F then 0x0002, each 1 cycle after its address, with no dump activity.
- Dump running and `i_cpu_en`=1 for 5 cycles during ISSUE → `o_mem_addr` follows the CPU for all 5 cycles; the dump word appears exactly 5 cycles later, with correct data.
- Ready low for 10 cycles in HOLD → `o_dump_valid`, `o_dump_data` and `o_dump_addr` stay stable; the word is accepted on the first ready cycle and the counter advances by exactly 1.
- `i_reset`=0 asserted during word 2 of 4 → outputs return to reset values immediately with no done pulse; a new start afterwards dumps from address 0.
- Second start pulse issued while busy → ignored; exactly DUMP_LEN words and one done pulse are produced.

Source files
------------

// File: rtl/arbitro_memoria_datos_pkg.sv
// Shared widths and dump sequencer state encoding for the data-memory arbiter.
package arbitro_memoria_datos_pkg;

  localparam int RAM_WIDTH_DEF  = 16;
  localparam int ADDR_WIDTH_DEF = 11;
  localparam int DUMP_LEN_DEF   = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } dump_state_t;

endpackage

// File: rtl/arbitro_memoria_datos_secuenciador_dump.sv
// Dump sequencer: walks addresses 0..DUMP_LEN-1 on idle memory cycles and
// presents each word on a valid/ready port, held stable until accepted.
module secuenciador_dump
  import arbitro_memoria_datos_pkg::*;
#(
  parameter int RAM_WIDTH  = RAM_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DUMP_LEN   = DUMP_LEN_DEF
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_en,
  input  logic                  start,
  input  logic                  ready,
  input  logic [RAM_WIDTH-1:0]  mem_data,
  output logic                  issue,
  output logic [ADDR_WIDTH-1:0] count,
  output logic                  valid,
  output logic [RAM_WIDTH-1:0]  data,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DUMP_LEN - 1);

  dump_state_t           state, state_next;
  logic [ADDR_WIDTH-1:0] cnt, cnt_next;
  logic                  capture;
  logic                  done_next;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    done_next  = 1'b0;
    case (state)
      // A start coinciding with the done pulse is dropped, not queued.
      ST_IDLE: begin
        if (start && !done) begin
          cnt_next   = '0;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!cpu_en) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        capture    = 1'b1;
        state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (ready) begin
          if (cnt == LAST_ADDR) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end else begin
            cnt_next   = cnt + ADDR_WIDTH'(1);
            state_next = ST_ISSUE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      data  <= '0;
      addr  <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      done  <= done_next;
      if (capture) begin
        data <= mem_data;
        addr <= cnt;
      end
    end
  end

  // Busy spans the done cycle even though the FSM is already back in IDLE.
  assign issue = (state == ST_ISSUE);
  assign valid = (state == ST_HOLD);
  assign busy  = (state != ST_IDLE) || done;
  assign count = cnt;

endmodule

// File: rtl/arbitro_memoria_datos.sv
// Shares the data memory between the CPU (absolute priority, never stalled)
// and the dump sequencer, which only uses cycles the CPU leaves free.
module arbitro_memoria_datos
  import arbitro_memoria_datos_pkg::*;
#(
  parameter int RAM_WIDTH  = RAM_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DUMP_LEN   = DUMP_LEN_DEF
)(
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_cpu_en,
  input  logic                  i_cpu_wea,
  input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
  input  logic [RAM_WIDTH-1:0]  i_cpu_data,
  output logic [RAM_WIDTH-1:0]  o_cpu_data,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [RAM_WIDTH-1:0]  o_mem_data,
  output logic                  o_mem_wea,
  input  logic [RAM_WIDTH-1:0]  i_mem_data,
  input  logic                  i_dump_start,
  input  logic                  i_dump_ready,
  output logic                  o_dump_valid,
  output logic [RAM_WIDTH-1:0]  o_dump_data,
  output logic [ADDR_WIDTH-1:0] o_dump_addr,
  output logic                  o_dump_busy,
  output logic                  o_dump_done
);

  logic                  dump_issue;
  logic [ADDR_WIDTH-1:0] dump_count;

  secuenciador_dump #(
    .RAM_WIDTH  (RAM_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DUMP_LEN   (DUMP_LEN)
  ) u_secuenciador_dump (
    .clk      (i_clk),
    .rst_n    (i_reset),
    .cpu_en   (i_cpu_en),
    .start    (i_dump_start),
    .ready    (i_dump_ready),
    .mem_data (i_mem_data),
    .issue    (dump_issue),
    .count    (dump_count),
    .valid    (o_dump_valid),
    .data     (o_dump_data),
    .addr     (o_dump_addr),
    .busy     (o_dump_busy),
    .done     (o_dump_done)
  );

  // The dump side only ever reads; write enable is purely the CPU's.
  always_comb begin
    o_mem_addr = i_cpu_addr;
    o_mem_wea  = 1'b0;
    if (i_cpu_en) begin
      o_mem_wea = i_cpu_wea;
    end else if (dump_issue) begin
      o_mem_addr = dump_count;
    end
  end

  assign o_cpu_data = i_mem_data;
  assign o_mem_data = i_cpu_data;

endmodule

// File: tb/tb_arbitro_memoria_datos.sv
// Bench for arbitro_memoria_datos: directed scenarios plus random CPU/dump traffic
// against a shadow-memory reference model.
module tb_arbitro_memoria_datos;

  localparam int RW = 16;
  localparam int AW = 11;
  localparam int DL = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_en, cpu_wea;
  logic [AW-1:0] cpu_addr;
  logic [RW-1:0] cpu_wdata, cpu_rdata;
  logic [AW-1:0] mem_addr;
  logic [RW-1:0] mem_wdata, mem_rdata;
  logic          mem_wea;
  logic          dump_start, dump_ready;
  logic          dump_valid, dump_busy, dump_done;
  logic [RW-1:0] dump_data;
  logic [AW-1:0] dump_addr;

  always #5 clk = ~clk;

  arbitro_memoria_datos #(.RAM_WIDTH(RW), .ADDR_WIDTH(AW), .DUMP_LEN(DL)) dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_cpu_en(cpu_en), .i_cpu_wea(cpu_wea), .i_cpu_addr(cpu_addr),
    .i_cpu_data(cpu_wdata), .o_cpu_data(cpu_rdata),
    .o_mem_addr(mem_addr), .o_mem_data(mem_wdata), .o_mem_wea(mem_wea),
    .i_mem_data(mem_rdata),
    .i_dump_start(dump_start), .i_dump_ready(dump_ready),
    .o_dump_valid(dump_valid), .o_dump_data(dump_data), .o_dump_addr(dump_addr),
    .o_dump_busy(dump_busy), .o_dump_done(dump_done)
  );

  // Memory with registered read (read-before-write).
  logic [RW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_wea) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [RW-1:0] shadow   [0:15];
  logic [RW-1:0] exp_dump [0:DL-1];

  // Dump monitor: samples 1 time unit before each rising edge.
  int words = 0, dones = 0, nxt_addr = 0, acc_cyc = 0;
  int vrise[$];
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    #4;
    if (!rst_n) begin
      nxt_addr = 0;
      prev_valid = 1'b0;
    end else begin
      if (dump_valid && !prev_valid) vrise.push_back(cyc);
      prev_valid = dump_valid;
      if (dump_valid && dump_ready) begin
        check("dump_addr", dump_addr, nxt_addr);
        check("dump_data", dump_data, (nxt_addr < DL) ? exp_dump[nxt_addr] : 16'hDEAD);
        acc_cyc = cyc;
        nxt_addr++;
        words++;
      end
      if (dump_done) begin
        check("done_word_count", nxt_addr, DL);
        check("busy_at_done", dump_busy, 1);
        check("done_after_last_accept", cyc, acc_cyc + 1);
        dones++;
        nxt_addr = 0;
      end
    end
  end

  logic          pend_vld = 1'b0;
  logic [RW-1:0] pend_exp;
  int            tick_cyc;

  // One cycle: drive inputs at the falling edge, check combinational paths 1 unit later.
  task automatic tick(input logic en, input logic wea, input logic [AW-1:0] addr,
                      input logic [RW-1:0] wdata, input logic st, input logic rdy);
    @(negedge clk);
    tick_cyc   = cyc;
    cpu_en     = en;
    cpu_wea    = wea;
    cpu_addr   = addr;
    cpu_wdata  = wdata;
    dump_start = st;
    dump_ready = rdy;
    #1;
    if (pend_vld) check("cpu_read_data", cpu_rdata, pend_exp);
    check("mem_wdata_passthru", mem_wdata, wdata);
    if (en) begin
      check("mem_addr_cpu", mem_addr, addr);
      check("mem_wea_cpu", mem_wea, wea);
    end else begin
      check("mem_wea_dump_never_writes", mem_wea, 0);
      if (!dump_busy) check("mem_addr_idle", mem_addr, addr);
    end
    pend_vld = en && !wea;
    if (en && !wea) pend_exp = shadow[addr[3:0]];
    if (en && wea) shadow[addr[3:0]] = wdata;
  endtask

  task automatic wait_done(input int lim);
    int n = 0;
    int b = dones;
    while (dones == b && n < lim) begin
      tick(0, 0, 0, 0, 0, 1);
      n++;
    end
    check("done_timeout", dones != b, 1);
  endtask

  task automatic load_exp();
    for (int a = 0; a < DL; a++) exp_dump[a] = shadow[a];
  endtask

  initial begin
    int sc, vb, bw, bd, n;
    logic [RW-1:0] hd;
    logic [AW-1:0] ha;

    // Reset state
    rst_n = 1'b0; cpu_en = 1'b1; cpu_wea = 1'b1; cpu_addr = '0; cpu_wdata = '0;
    dump_start = 1'b0; dump_ready = 1'b1;
    #12;
    check("rst_valid", dump_valid, 0);
    check("rst_busy", dump_busy, 0);
    check("rst_done", dump_done, 0);
    check("rst_data", dump_data, 0);
    check("rst_addr", dump_addr, 0);
    check("rst_wea_follows_cpu", mem_wea, 1);
    cpu_en = 1'b0;
    #1;
    check("rst_wea_cpu_off", mem_wea, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Preload via CPU writes: mem[a] = a + 0x0100
    for (int a = 0; a < 16; a++) tick(1, 1, a, 16'h0100 + a, 0, 1);

    // Plain dump, no contention
    load_exp();
    vb = vrise.size(); bw = words;
    tick(0, 0, 0, 0, 1, 1); sc = tick_cyc;
    check("busy_start_cycle", dump_busy, 0);
    tick(0, 0, 0, 0, 0, 1);
    check("busy_after_start", dump_busy, 1);
    wait_done(100);
    check("plain_word_count", words - bw, DL);
    check("plain_first_latency", (vrise.size() > vb) ? vrise[vb] - sc : -1, 3);
    for (int k = 1; k < DL; k++)
      check("plain_throughput", (vrise.size() > vb + k) ? vrise[vb+k] - vrise[vb+k-1] : -1, 3);
    check("busy_after_done", dump_busy, 0);
    check("valid_after_done", dump_valid, 0);

    // CPU write then read back
    tick(1, 1, 0, 16'h000F, 0, 1);
    tick(1, 1, 1, 16'h0002, 0, 1);
    tick(1, 0, 0, 0, 0, 1);
    tick(1, 0, 1, 0, 0, 1);
    check("cpu_rd_addr0", cpu_rdata, 16'h000F);
    tick(0, 0, 0, 0, 0, 1);
    check("cpu_rd_addr1", cpu_rdata, 16'h0002);
    check("cpu_only_no_dump", dump_busy, 0);

    // CPU blocks the first ISSUE for 5 cycles
    load_exp();
    vb = vrise.size();
    tick(0, 0, 0, 0, 1, 1); sc = tick_cyc;
    for (int k = 0; k < 5; k++) tick(1, 0, 7, 0, 0, 1);
    wait_done(100);
    check("blocked_first_latency", (vrise.size() > vb) ? vrise[vb] - sc : -1, 8);

    // Ready held low in HOLD; CPU writes ahead of and behind the dump pointer
    load_exp();
    tick(0, 0, 0, 0, 1, 0);
    n = 0;
    while (!dump_valid && n < 20) begin tick(0, 0, 0, 0, 0, 0); n++; end
    check("hold_valid_seen", dump_valid, 1);
    hd = dump_data; ha = dump_addr;
    check("hold_first_addr", ha, 0);
    check("hold_first_data", hd, exp_dump[0]);
    for (int k = 0; k < 10; k++) begin
      if (k == 1) begin tick(1, 1, 3, 16'hABCD, 0, 0); exp_dump[3] = 16'hABCD; end
      else if (k == 2) tick(1, 1, 0, 16'h5555, 0, 0);
      else tick(0, 0, 0, 0, 0, 0);
      check("hold_valid_stable", dump_valid, 1);
      check("hold_data_stable", dump_data, hd);
      check("hold_addr_stable", dump_addr, ha);
    end
    bw = words;
    tick(0, 0, 0, 0, 0, 1);
    wait_done(100);
    check("hold_rest_words", words - bw, DL);

    // Async reset in the middle of word 2
    load_exp();
    bw = words; bd = dones;
    tick(0, 0, 0, 0, 1, 1);
    n = 0;
    while (words - bw < 2 && n < 40) begin tick(0, 0, 0, 0, 0, 1); n++; end
    check("pre_reset_words", words - bw, 2);
    @(negedge clk);
    rst_n = 1'b0;
    pend_vld = 1'b0;
    #1;
    check("abort_valid", dump_valid, 0);
    check("abort_busy", dump_busy, 0);
    check("abort_data", dump_data, 0);
    check("abort_addr", dump_addr, 0);
    @(negedge clk);
    @(negedge clk);
    check("abort_done", dump_done, 0);
    rst_n = 1'b1;
    tick(0, 0, 0, 0, 0, 1);
    check("abort_no_done_pulse", dones - bd, 0);
    bw = words;
    tick(0, 0, 0, 0, 1, 1);
    wait_done(100);
    check("restart_words", words - bw, DL);

    // Second start while busy is ignored
    bw = words; bd = dones;
    tick(0, 0, 0, 0, 1, 1);
    for (int k = 0; k < 4; k++) tick(0, 0, 0, 0, (k == 3), 1);
    wait_done(100);
    for (int k = 0; k < 15; k++) tick(0, 0, 0, 0, 0, 1);
    check("restart_ignored_words", words - bw, DL);
    check("restart_ignored_dones", dones - bd, 1);
    check("restart_ignored_idle", dump_busy, 0);

    // Random traffic: CPU writes stay above the dump window
    load_exp();
    for (int k = 0; k < 400; k++) begin
      logic en, wea;
      wea = 1'($urandom % 2);
      en  = 1'($urandom % 2);
      tick(en, wea, wea ? AW'(4 + $urandom % 12) : AW'($urandom % 16),
           RW'($urandom), ($urandom % 8) == 0, ($urandom % 4) != 0);
    end
    n = 0;
    while (dump_busy && n < 200) begin tick(0, 0, 0, 0, 0, 1); n++; end
    check("random_drain_idle", dump_busy, 0);
    check("random_dumps_completed", dones > bd + 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
